fft_result_sink: RTL
====================

Name: fft_result_sink

Overview:
- Receiving end of the FFT output stream: accepts WDATA/WVALID/WBURST beats from top_fft and drives WREADY.
- Stores each complex result in an internal dual-port buffer and checks frame length against SAMP_NUMBER.
- Tracks the peak-magnitude bin during capture.
- Exposes a 1-cycle-latency host readout port; sits between top_fft and the host/AXI-side register logic.

Parameters:
- DATA_WIDTH, 32, beat width; packed {re[31:16], im[15:0]}, both signed two's complement.
- ADDR_WIDTH, 12, buffer address width; depth = 2**ADDR_WIDTH = 4096 entries.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- n_Reset  in  1  synchronous active-low reset.
- start  in  1  single-cycle pulse; arms a capture of SAMP_NUMBER beats.
- SAMP_NUMBER  in  12  frame length, sampled on start.
- WDATA  in  DATA_WIDTH  result beat from FFT.
- WVALID  in  1  beat valid.
- WREADY  out  1  sink ready.
- WBURST  in  2  beat position: 00 SINGLE, 01 FIRST, 10 CONT, 11 LAST.
- busy  out  1  high in CAPTURE.
- done  out  1  high in DONE.
- len_err  out  1  frame length mismatch or zero length.
- beat_count  out  13  beats accepted in current frame.
- peak_index  out  12  address of largest |re|+|im|.
- peak_mag  out  17  that magnitude.
- rd_addr  in  12  host read address.
- rd_data  out  DATA_WIDTH  buffer[rd_addr], registered.

Behaviour:
- Reset (n_Reset=0 at posedge): state IDLE; WREADY=0, busy=0, done=0, len_err=0, beat_count=0, peak_index=0, peak_mag=0, rd_data=0. Buffer contents are not cleared.
- States: IDLE, CAPTURE, DONE.
- IDLE:
  - start with SAMP_NUMBER!=0 latches n=SAMP_NUMBER, clears beat_count/peak/len_err, and goes to CAPTURE next cycle.
  - start with SAMP_NUMBER==0 sets len_err=1 and enters DONE.
- CAPTURE:
  - WREADY=1 registered (asserted the cycle after start, deasserted the cycle after the terminating beat).
  - A beat is accepted on a posedge where WVALID&&WREADY; WDATA is written to buffer[beat_count[11:0]] and beat_count increments.
  - Terminating beat is whichever comes first: WBURST==LAST, or beat_count==n-1. Next state is DONE.
  - len_err=1 if LAST arrives at beat_count!=n-1, or beat n-1 arrives without LAST.
  - SINGLE is legal only when n==1; otherwise it is treated as CONT and does not terminate.
  - FIRST/CONT order is not checked.
- DONE:
  - WREADY=0, done=1; beat_count, peak and len_err hold.
  - start re-arms exactly as from IDLE, so done drops the cycle after start.
- Simultaneous start during CAPTURE: ignored.
- Reset mid-capture: immediate return to IDLE; a partial frame is discarded (flags cleared).
- Peak tracking:
  - mag = |re| + |im|, unsigned 17 bits; |-32768| = 32768 is representable.
  - Computed combinationally on the accepted beat; peak registers update on the same edge.
  - Update only when mag > peak_mag (strict), so ties keep the lowest index.
  - The first accepted beat always loads the peak (peak_mag compared with "frame-empty" bypass).
- Readout:
  - rd_data <= buffer[rd_addr] every cycle, valid one cycle after rd_addr.
  - Same-address read during write returns old data.
  - Available in all states.

Decomposition:
- Package fft_stream_pkg holds:
  - DATA_WIDTH, ADDR_WIDTH defaults.
  - typedef enum logic[1:0] burst_t {BURST_SINGLE, BURST_FIRST, BURST_CONT, BURST_LAST}.
  - typedef enum sink_state_t {S_IDLE, S_CAPTURE, S_DONE}.
  - Function abs_sum(re, im) returning 17 bits.
- One sub-module, result_ram: simple dual-port (1 write, 1 registered read), DEPTH=2**ADDR_WIDTH, read-old-on-collision.

Test Plan:
- Reset, then start with SAMP_NUMBER=10; drive 10 beats WDATA=k*0x00010001 (k=0..9), LAST on k=9, WVALID held high -> WREADY high 10 cycles, done=1, beat_count=10, len_err=0, rd_addr=3 gives rd_data=0x00030003 next cycle, peak_index=9, peak_mag=18.
- Same frame with WVALID toggled 1-0-1 -> still exactly 10 writes, no duplicates, identical buffer contents.
- SAMP_NUMBER=8, LAST on beat 5 -> DONE after 6 beats, len_err=1, beat_count=6; SAMP_NUMBER=4, no LAST -> DONE after 4, len_err=1.
- Peak/ties: beats {0x80000000, 0x7FFF0001, 0x00018000} -> mag 32768, 32768, 32769; peak_index=2, peak_mag=32769. Variant with the third beat removed -> peak_index=0.
- start with SAMP_NUMBER=0 -> done=1, len_err=1, WREADY never high. start during CAPTURE -> ignored.
- n_Reset low after beat 4 of 10 -> next cycle IDLE, WREADY=0, beat_count=0. New start with 10 beats completes cleanly with len_err=0.

Source files
------------

// File: rtl/fft_stream_pkg.sv
// Shared types, widths and helpers for the FFT result stream.
package fft_stream_pkg;

    localparam int unsigned DATA_WIDTH_DEF = 32;
    localparam int unsigned ADDR_WIDTH_DEF = 12;
    localparam int unsigned HALF_WIDTH     = 16;
    localparam int unsigned MAG_WIDTH      = HALF_WIDTH + 1;

    typedef enum logic [1:0] {
        BURST_SINGLE = 2'b00,
        BURST_FIRST  = 2'b01,
        BURST_CONT   = 2'b10,
        BURST_LAST   = 2'b11
    } burst_t;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_CAPTURE = 2'd1,
        S_DONE    = 2'd2
    } sink_state_t;

    // |re| + |im| on signed 16-bit halves; one extra bit so |-32768| fits.
    function automatic logic [MAG_WIDTH-1:0] abs_sum(input logic [HALF_WIDTH-1:0] re,
                                                     input logic [HALF_WIDTH-1:0] im);
        logic [MAG_WIDTH-1:0] re_x;
        logic [MAG_WIDTH-1:0] im_x;
        re_x = {re[HALF_WIDTH-1], re};
        im_x = {im[HALF_WIDTH-1], im};
        if (re[HALF_WIDTH-1]) re_x = ~re_x + MAG_WIDTH'(1);
        if (im[HALF_WIDTH-1]) im_x = ~im_x + MAG_WIDTH'(1);
        return re_x + im_x;
    endfunction

endpackage

// File: rtl/result_ram.sv
// Simple dual-port result buffer: one write port, one registered read port
// that returns the old word when reading the address being written.
module result_ram
    import fft_stream_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = fft_stream_pkg::DATA_WIDTH_DEF,
    parameter int unsigned ADDR_WIDTH = fft_stream_pkg::ADDR_WIDTH_DEF
) (
    input  logic                  clk,
    input  logic                  n_Reset,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data
);

    localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_addr] <= wr_data;
    end

    always_ff @(posedge clk) begin
        if (!n_Reset) rd_data <= '0;
        else          rd_data <= mem[rd_addr];
    end

endmodule

// File: rtl/fft_result_sink.sv
// Receiving end of the FFT result stream: captures one frame into a buffer,
// checks its length, tracks the peak-magnitude bin and serves host reads.
module fft_result_sink
    import fft_stream_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = fft_stream_pkg::DATA_WIDTH_DEF,
    parameter int unsigned ADDR_WIDTH = fft_stream_pkg::ADDR_WIDTH_DEF
) (
    input  logic                  clk,
    input  logic                  n_Reset,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] SAMP_NUMBER,
    input  logic [DATA_WIDTH-1:0] WDATA,
    input  logic                  WVALID,
    output logic                  WREADY,
    input  logic [1:0]            WBURST,
    output logic                  busy,
    output logic                  done,
    output logic                  len_err,
    output logic [ADDR_WIDTH:0]   beat_count,
    output logic [ADDR_WIDTH-1:0] peak_index,
    output logic [MAG_WIDTH-1:0]  peak_mag,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data
);

    sink_state_t           state;
    sink_state_t           state_next;
    logic [ADDR_WIDTH-1:0] n_len;
    logic                  accept;
    logic                  at_last;
    logic                  end_flag;
    logic                  terminate;
    logic                  arm;
    logic [MAG_WIDTH-1:0]  mag;

    // Handshake decode and next-state logic.
    always_comb begin
        accept     = WVALID && WREADY;
        at_last    = (beat_count == ({1'b0, n_len} - (ADDR_WIDTH+1)'(1)));
        end_flag   = (WBURST == BURST_LAST) ||
                     ((WBURST == BURST_SINGLE) && (n_len == ADDR_WIDTH'(1)));
        terminate  = accept && (end_flag || at_last);
        arm        = start && (state != S_CAPTURE);
        mag        = abs_sum(WDATA[DATA_WIDTH-1 -: HALF_WIDTH], WDATA[HALF_WIDTH-1:0]);
        state_next = state;
        case (state)
            S_IDLE, S_DONE: begin
                if (start) state_next = (SAMP_NUMBER != '0) ? S_CAPTURE : S_DONE;
            end
            S_CAPTURE: begin
                if (terminate) state_next = S_DONE;
            end
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!n_Reset) state <= S_IDLE;
        else          state <= state_next;
    end

    // Status flags follow the next state so they line up with the state register.
    always_ff @(posedge clk) begin
        if (!n_Reset) begin
            WREADY     <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            len_err    <= 1'b0;
            beat_count <= '0;
            peak_index <= '0;
            peak_mag   <= '0;
            n_len      <= '0;
        end else begin
            WREADY <= (state_next == S_CAPTURE);
            busy   <= (state_next == S_CAPTURE);
            done   <= (state_next == S_DONE);
            if (arm) begin
                n_len      <= SAMP_NUMBER;
                beat_count <= '0;
                peak_index <= '0;
                peak_mag   <= '0;
                len_err    <= (SAMP_NUMBER == '0);
            end else if (accept) begin
                beat_count <= beat_count + (ADDR_WIDTH+1)'(1);
                // First beat of the frame always loads; later ties keep the lower index.
                if ((beat_count == '0) || (mag > peak_mag)) begin
                    peak_index <= beat_count[ADDR_WIDTH-1:0];
                    peak_mag   <= mag;
                end
                if (end_flag != at_last) len_err <= 1'b1;
            end
        end
    end

    result_ram #(
        .DATA_WIDTH(DATA_WIDTH),
        .ADDR_WIDTH(ADDR_WIDTH)
    ) u_ram (
        .clk    (clk),
        .n_Reset(n_Reset),
        .wr_en  (accept),
        .wr_addr(beat_count[ADDR_WIDTH-1:0]),
        .wr_data(WDATA),
        .rd_addr(rd_addr),
        .rd_data(rd_data)
    );

endmodule
